// File: rtl/cmul_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cmul_rr_arbiter
//  Description : Round-robin shared 2-stage pipelined Q1.31 complex multiplier.
//                NUM_REQ requesters with valid/ready, one tagged result port.
//                Optional macro CMUL_SAT_EN: saturate the rounded partial
//                products and the final re/im add/sub instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module cmul_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*64-1:0]  req_a,
  input  logic [NUM_REQ*64-1:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [63:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

  // Rounded Q1.31 product: round-half-up at bit 30, then keep 32 bits.
  function automatic logic [31:0] mr(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    p = $signed(x) * $signed(y);
    p = p + 64'sd1073741824;
    p = p >>> 31;
`ifdef CMUL_SAT_EN
    if (!p[63] && (|p[62:31]))
      return 32'h7FFF_FFFF;
    if (p[63] && !(&p[62:31]))
      return 32'h8000_0000;
`endif
    return p[31:0];
  endfunction

  // Pipeline state
  logic [ID_W-1:0] r_ptr;
  logic            r_s1_valid;
  logic [ID_W-1:0] r_s1_id;
  logic [31:0]     r_s1_rr;
  logic [31:0]     r_s1_ii;
  logic [31:0]     r_s1_ri;
  logic [31:0]     r_s1_ir;
  logic            r_rsp_valid;
  logic [63:0]     r_rsp_data;
  logic [ID_W-1:0] r_rsp_id;

  // Combinational signals
  logic            w_adv;
  logic            w_gnt_any;
  logic [ID_W-1:0] w_gnt_id;
  logic            w_xfer;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [63:0]     w_sel_a;
  logic [63:0]     w_sel_b;
  logic [31:0]     w_re;
  logic [31:0]     w_im;

  // A single global enable: everything moves only when the output can drain.
  assign w_adv = !r_rsp_valid || rsp_ready;

  // Round-robin search starting at r_ptr; scanning backwards lets the
  // first-in-order hit be the final assignment.
  always_comb begin
    int idx;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = idx[ID_W-1:0];
      end
    end
  end

  assign w_xfer    = w_gnt_any && w_adv && rst_n;
  assign w_ptr_nxt = (w_gnt_id == c_last_id) ? '0 : w_gnt_id + ID_W'(1);
  assign w_sel_a   = req_a[int'(w_gnt_id)*64 +: 64];
  assign w_sel_b   = req_b[int'(w_gnt_id)*64 +: 64];

  // One-hot accept, suppressed during stall and while reset is held.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign req_ready[i] = w_gnt_any && (w_gnt_id == ID_W'(i)) && w_adv && rst_n;
  end

  // Rotate priority past the requester that was just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (w_xfer)
      r_ptr <= w_ptr_nxt;
  end

  // Stage 1: capture the four rounded partial products and the issuing id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_rr    <= '0;
      r_s1_ii    <= '0;
      r_s1_ri    <= '0;
      r_s1_ir    <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_id <= w_gnt_id;
        r_s1_rr <= mr(w_sel_a[63:32], w_sel_b[63:32]);
        r_s1_ii <= mr(w_sel_a[31:0],  w_sel_b[31:0]);
        r_s1_ri <= mr(w_sel_a[63:32], w_sel_b[31:0]);
        r_s1_ir <= mr(w_sel_a[31:0],  w_sel_b[63:32]);
      end
    end
  end

  // Combine partials: re = rr - ii, im = ri + ir.
  always_comb begin
`ifdef CMUL_SAT_EN
    logic [32:0] re_w;
    logic [32:0] im_w;
    re_w = {r_s1_rr[31], r_s1_rr} - {r_s1_ii[31], r_s1_ii};
    im_w = {r_s1_ri[31], r_s1_ri} + {r_s1_ir[31], r_s1_ir};
    w_re = re_w[31:0];
    w_im = im_w[31:0];
    if (re_w[32] != re_w[31])
      w_re = re_w[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (im_w[32] != im_w[31])
      w_im = im_w[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    w_re = r_s1_rr - r_s1_ii;
    w_im = r_s1_ri + r_s1_ir;
`endif
  end

  // Stage 2: output register, refilled whenever the pipeline advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else if (w_adv) begin
      r_rsp_valid <= r_s1_valid;
      r_rsp_data  <= {w_re, w_im};
      r_rsp_id    <= r_s1_id;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_s1_valid || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_cmul_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmul_rr_arbiter
//  Description : Directed self-checking bench for cmul_rr_arbiter (NUM_REQ=4).
//                Honours CMUL_SAT_EN for the saturation expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmul_rr_arbiter;

  localparam int NUM_REQ = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         busy;

  int n_cmp;
  int n_err;

  cmul_rr_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester i: A = 0.5, B = i/8  ->  product re = i << 27, im = 0.
  task automatic load_ramp_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[64*i +: 64] = {32'h4000_0000, 32'h0};
      req_b[64*i +: 64] = {32'(i) << 28, 32'h0};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
    req_a = '0; req_b = '0;
    #2;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 64'h0) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    tick();
    req_valid = 4'b0000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_a[0 +: 64] = {32'h4000_0000, 32'h4000_0000};
    req_b[0 +: 64] = {32'h4000_0000, 32'h0};
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL t1_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b want 1", busy); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 64'h2000_0000_2000_0000) begin n_err++; $display("FAIL t1_data: got %h want 2000000020000000", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL t1_id: got %0d want 0", rsp_id); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL t1_drain_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_drain_busy: got %b want 0", busy); end
  endtask

  // ptr is 1 here; the only active requester (2) must still win.
  task automatic test_latency();
    req_a[128 +: 64] = {32'h0, 32'h4000_0000};
    req_b[128 +: 64] = {32'h0, 32'h4000_0000};
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL t2_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL t2_early_valid: got %b want 0", rsp_valid); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL t2_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 64'hE000_0000_0000_0000) begin n_err++; $display("FAIL t2_data: got %h want e000000000000000", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL t2_id: got %0d want 2", rsp_id); end
    tick();
  endtask

  // ptr is 3 here: grants must run 3,0,1,2,3,0,1,2 with results 2 clk behind.
  task automatic test_round_robin();
    int exp_gnt [8];
    exp_gnt = '{3, 0, 1, 2, 3, 0, 1, 2};
    load_ramp_ops();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++; if (req_ready !== (4'b0001 << exp_gnt[k])) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want grant %0d", k, req_ready, exp_gnt[k]); end
      if (k >= 2) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_gnt[k-2])) begin n_err++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, exp_gnt[k-2]); end
        n_cmp++; if (rsp_data !== {32'(exp_gnt[k-2]) << 27, 32'h0}) begin n_err++; $display("FAIL rr_data[%0d]: got %h want id %0d product", k, rsp_data, exp_gnt[k-2]); end
      end
      tick();
    end
    req_valid = 4'b0000;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin n_err++; $display("FAIL rr_tail0: got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin n_err++; $display("FAIL rr_tail1: got v=%b id=%0d want v=1 id=2", rsp_valid, rsp_id); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rr_idle: got v=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  // ptr is 3: requesters 1 and 2 fill the pipe, then the output stalls 5 clk.
  task automatic test_stall();
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL st_ready0: got %b want 0010", req_ready); end
    tick();
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL st_ready1: got %b want 0100", req_ready); end
    tick();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin n_err++; $display("FAIL st_hold_id[%0d]: got v=%b id=%0d want v=1 id=1", k, rsp_valid, rsp_id); end
      n_cmp++; if (rsp_data !== 64'h0800_0000_0000_0000) begin n_err++; $display("FAIL st_hold_data[%0d]: got %h want 0800000000000000", k, rsp_data); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL st_hold_ready[%0d]: got %b want 0000", k, req_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL st_hold_busy[%0d]: got %b want 1", k, busy); end
      tick();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin n_err++; $display("FAIL st_out0: got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin n_err++; $display("FAIL st_out1: got v=%b id=%0d want v=1 id=2", rsp_valid, rsp_id); end
    n_cmp++; if (rsp_data !== 64'h1000_0000_0000_0000) begin n_err++; $display("FAIL st_out1_data: got %h want 1000000000000000", rsp_data); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL st_no_dup: got %b want 0", rsp_valid); end
  endtask

  // (-1)*(-1) on the real part of req0, then on the imaginary part of req3.
  task automatic test_wrap_sat();
    logic [63:0] exp_rr;
    logic [63:0] exp_ii;
`ifdef CMUL_SAT_EN
    exp_rr = 64'h7FFF_FFFF_0000_0000;
    exp_ii = 64'h8000_0001_0000_0000;
`else
    exp_rr = 64'h8000_0000_0000_0000;
    exp_ii = 64'h8000_0000_0000_0000;
`endif
    req_a[0   +: 64] = {32'h8000_0000, 32'h0};
    req_b[0   +: 64] = {32'h8000_0000, 32'h0};
    req_a[192 +: 64] = {32'h0, 32'h8000_0000};
    req_b[192 +: 64] = {32'h0, 32'h8000_0000};
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== exp_rr) begin n_err++; $display("FAIL sat_rr: got v=%b %h want v=1 %h", rsp_valid, rsp_data, exp_rr); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== exp_ii) begin n_err++; $display("FAIL sat_ii: got v=%b id=%0d %h want v=1 id=3 %h", rsp_valid, rsp_id, rsp_data, exp_ii); end
    tick();
  endtask

  // Reset with two ops in flight; then the pointer must restart at 0.
  task automatic test_reset_midflight();
    load_ramp_ops();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL mr_pre_valid: got %b want 1", rsp_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mr_async: got v=%b busy=%b want 0 0", rsp_valid, busy); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mr_stay_low[%0d]: got %b want 0", k, rsp_valid); end
      tick();
    end
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mr_ptr_restart: got %b want 0001", req_ready); end
    req_valid = 4'b0000;
    tick();
  endtask

  // A single requester held high is granted every cycle.
  task automatic test_back_to_back();
    req_valid = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 4) ? 4'b1000 : 4'b0000;
      #1;
      if (k < 4) begin
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1000", k, req_ready); end
      end
      if (k >= 2) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin n_err++; $display("FAIL b2b_rsp[%0d]: got v=%b id=%0d want v=1 id=3", k, rsp_valid, rsp_id); end
      end
      tick();
    end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", rsp_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_latency();
    test_round_robin();
    test_stall();
    test_wrap_sat();
    test_reset_midflight();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
